// File: rtl/rom_dl_packer.sv
// ============================================================================
// Module  : rom_dl_packer
// Brief   : Packs ROM download bytes into 16-bit big-endian SDRAM words,
//           buffers them in a small FIFO and flags completion of the upload.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_dl_packer #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          ADDR_W     = 25,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              wr_req,
    output logic [ADDR_W-2:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [1:0]        wr_be,
    input  logic              wr_ack,
    output logic              rom_loaded,
    output logic              overflow
);

    localparam int c_aw      = $clog2(FIFO_DEPTH);
    localparam int c_ptr_w   = c_aw + 1;
    localparam int c_entry_w = (ADDR_W - 1) + 16 + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_active_d;
    logic                r_restart, w_restart_nxt;
    logic                r_hold_valid, w_hold_valid_nxt;
    logic [ADDR_W-2:0]   r_hold_addr, w_hold_addr_nxt;
    logic [15:0]         r_hold_data, w_hold_data_nxt;
    logic [1:0]          r_hold_mask, w_hold_mask_nxt;
    logic                r_rom_loaded, r_overflow;

    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wptr, r_rptr;
    logic [c_entry_w-1:0] w_head;

    logic                 w_rise, w_fall;
    logic                 w_full, w_empty, w_pop, w_space, w_write;
    logic                 w_push, w_set_loaded;
    logic [c_entry_w-1:0] w_push_entry;
    logic [ADDR_W-2:0]    w_byte_waddr;
    logic [1:0]           w_bm;
    logic [15:0]          w_cap_data, w_mrg_data;

    assign w_rise = dl_active & ~r_active_d;
    assign w_fall = ~dl_active & r_active_d;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_ptr_w-1] != r_rptr[c_ptr_w-1]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_pop   = wr_ack & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_space = ~w_full | w_pop;
    assign w_write = w_push & w_space;

    assign w_byte_waddr = dl_addr[ADDR_W-1:1];
    assign w_bm         = dl_addr[0] ? 2'b01 : 2'b10;
    assign w_cap_data   = dl_addr[0] ? {PAD_BYTE, dl_data} : {dl_data, PAD_BYTE};
    assign w_mrg_data   = dl_addr[0] ? {r_hold_data[15:8], dl_data}
                                     : {dl_data, r_hold_data[7:0]};

    always_comb begin
        w_state_nxt      = r_state;
        w_restart_nxt    = r_restart;
        w_hold_valid_nxt = r_hold_valid;
        w_hold_addr_nxt  = r_hold_addr;
        w_hold_data_nxt  = r_hold_data;
        w_hold_mask_nxt  = r_hold_mask;
        w_push           = 1'b0;
        w_push_entry     = {r_hold_addr, r_hold_data, r_hold_mask};
        w_set_loaded     = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_rise) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (dl_wr) begin
                    if (r_hold_valid && (r_hold_addr == w_byte_waddr) &&
                        ((r_hold_mask & w_bm) == 2'b00)) begin
                        // Held word always has exactly one half, so a merge completes it.
                        w_push           = 1'b1;
                        w_push_entry     = {r_hold_addr, w_mrg_data, 2'b11};
                        w_hold_valid_nxt = 1'b0;
                    end else begin
                        w_push           = r_hold_valid;
                        w_hold_valid_nxt = 1'b1;
                        w_hold_addr_nxt  = w_byte_waddr;
                        w_hold_data_nxt  = w_cap_data;
                        w_hold_mask_nxt  = w_bm;
                    end
                end
                if (w_fall) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_rise) w_restart_nxt = 1'b1;
                if (r_hold_valid) begin
                    if (w_space) begin
                        w_push           = 1'b1;
                        w_hold_valid_nxt = 1'b0;
                    end
                end else if (w_empty) begin
                    w_restart_nxt = 1'b0;
                    if (r_restart || w_rise) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt  = S_DONE;
                        w_set_loaded = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_active_d   <= 1'b0;
            r_restart    <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_hold_mask  <= '0;
            r_rom_loaded <= 1'b0;
            r_overflow   <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_active_d   <= dl_active;
            r_restart    <= w_restart_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_hold_addr  <= w_hold_addr_nxt;
            r_hold_data  <= w_hold_data_nxt;
            r_hold_mask  <= w_hold_mask_nxt;

            if (w_rise)
                r_rom_loaded <= 1'b0;
            else if (w_set_loaded)
                r_rom_loaded <= 1'b1;

            if (w_rise)
                r_overflow <= 1'b0;
            else if (w_push && !w_space)
                r_overflow <= 1'b1;

            if (w_write) r_wptr <= r_wptr + c_ptr_w'(1);
            if (w_pop)   r_rptr <= r_rptr + c_ptr_w'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_write) r_mem[r_wptr[c_aw-1:0]] <= w_push_entry;
    end

    // Outputs are forced to zero while empty so reset clears them asynchronously.
    assign w_head     = w_empty ? '0 : r_mem[r_rptr[c_aw-1:0]];
    assign wr_req     = ~w_empty;
    assign wr_addr    = w_head[c_entry_w-1 -: (ADDR_W-1)];
    assign wr_data    = w_head[17:2];
    assign wr_be      = w_head[1:0];
    assign rom_loaded = r_rom_loaded;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_rom_dl_packer.sv
// ============================================================================
// Module  : tb_rom_dl_packer
// Brief   : Directed self-checking bench for rom_dl_packer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_dl_packer;

    typedef struct packed {
        logic [23:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } word_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        wr_ack = 1'b0;
    logic        rom_loaded;
    logic        overflow;

    int    total = 0;
    int    bad = 0;
    bit    auto_ack = 1'b0;
    word_t got[$];
    word_t exp_w;
    word_t head;

    rom_dl_packer #(.FIFO_DEPTH(4), .ADDR_W(25), .PAD_BYTE(8'hFF)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .wr_ack    (wr_ack),
        .rom_loaded(rom_loaded),
        .overflow  (overflow)
    );

    initial forever #5 clk_sys = ~clk_sys;

    // SDRAM-side sink: accepts one word per cycle when enabled.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (auto_ack) begin
                if (wr_req === 1'b1) begin
                    got.push_back(word_t'({wr_addr, wr_data, wr_be}));
                    wr_ack = 1'b1;
                end else begin
                    wr_ack = 1'b0;
                end
            end
        end
    end

    task automatic start_dl;
        @(negedge clk_sys); dl_active = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic end_dl;
        @(negedge clk_sys); dl_active = 1'b0;
    endtask

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
    endtask

    task automatic wait_loaded(input string name);
        int n = 0;
        while (rom_loaded !== 1'b1 && n < 300) begin
            @(negedge clk_sys); n++;
        end
        total++;
        if (rom_loaded !== 1'b1) begin
            bad++; $display("FAIL %s: rom_loaded=%b required 1 (timeout)", name, rom_loaded);
        end
    endtask

    task automatic test_reset;
        @(negedge clk_sys);
        total++;
        if ({wr_req, wr_be, rom_loaded, overflow} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            bad++; $display("FAIL reset_state: req=%b be=%b loaded=%b ovf=%b addr=%h data=%h required all 0",
                            wr_req, wr_be, rom_loaded, overflow, wr_addr, wr_data);
        end
        @(negedge clk_sys); reset_n = 1'b1;
    endtask

    task automatic test_sequential;
        got.delete(); auto_ack = 1'b1;
        start_dl();
        put_byte(25'd0, 8'h12);
        put_byte(25'd1, 8'h34);
        total++;
        if (wr_req !== 1'b0) begin bad++; $display("FAIL seq_req_early: wr_req=%b required 0", wr_req); end
        put_byte(25'd2, 8'h56);
        total++;
        if (wr_req !== 1'b1) begin bad++; $display("FAIL seq_req_latency: wr_req=%b required 1", wr_req); end
        put_byte(25'd3, 8'h78);
        @(negedge clk_sys); dl_wr = 1'b0;
        total++;
        if (rom_loaded !== 1'b0) begin bad++; $display("FAIL seq_loaded_early: rom_loaded=%b required 0", rom_loaded); end
        end_dl();
        wait_loaded("seq_loaded");
        total++;
        if (got.size() != 2) begin bad++; $display("FAIL seq_count: words=%0d required 2", got.size()); end
        else begin
            exp_w = '{a: 24'd0, d: 16'h1234, be: 2'b11};
            total++;
            if (got[0] !== exp_w) begin bad++; $display("FAIL seq_word0: got %h required %h", got[0], exp_w); end
            exp_w = '{a: 24'd1, d: 16'h5678, be: 2'b11};
            total++;
            if (got[1] !== exp_w) begin bad++; $display("FAIL seq_word1: got %h required %h", got[1], exp_w); end
        end
    endtask

    task automatic test_odd_length;
        auto_ack = 1'b0; wr_ack = 1'b0; got.delete();
        start_dl();
        total++;
        if (rom_loaded !== 1'b0) begin bad++; $display("FAIL odd_loaded_clear: rom_loaded=%b required 0", rom_loaded); end
        put_byte(25'd0, 8'hAA);
        put_byte(25'd1, 8'hBB);
        put_byte(25'd2, 8'hCC);
        @(negedge clk_sys); dl_wr = 1'b0;
        end_dl();
        repeat (6) @(negedge clk_sys);
        head = word_t'({wr_addr, wr_data, wr_be});
        exp_w = '{a: 24'd0, d: 16'hAABB, be: 2'b11};
        total++;
        if (wr_req !== 1'b1 || head !== exp_w) begin
            bad++; $display("FAIL odd_head: req=%b head=%h required 1/%h", wr_req, head, exp_w);
        end
        total++;
        if (rom_loaded !== 1'b0) begin bad++; $display("FAIL odd_loaded_pending: rom_loaded=%b required 0", rom_loaded); end
        auto_ack = 1'b1;
        wait_loaded("odd_loaded");
        exp_w = '{a: 24'd1, d: 16'hCCFF, be: 2'b10};
        total++;
        if (got.size() != 2 || got[got.size()-1] !== exp_w) begin
            bad++; $display("FAIL odd_final_word: count=%0d last=%h required 2/%h",
                            got.size(), (got.size() > 0) ? got[got.size()-1] : word_t'(0), exp_w);
        end
    endtask

    task automatic test_addr_jump;
        auto_ack = 1'b0; wr_ack = 1'b0; got.delete();
        start_dl();
        put_byte(25'd4, 8'h11);
        put_byte(25'd9, 8'h22);
        @(negedge clk_sys); dl_wr = 1'b0;
        head = word_t'({wr_addr, wr_data, wr_be});
        exp_w = '{a: 24'd2, d: 16'h11FF, be: 2'b10};
        total++;
        if (wr_req !== 1'b1 || head !== exp_w) begin
            bad++; $display("FAIL jump_first: req=%b head=%h required 1/%h", wr_req, head, exp_w);
        end
        end_dl();
        auto_ack = 1'b1;
        wait_loaded("jump_loaded");
        exp_w = '{a: 24'd4, d: 16'hFF22, be: 2'b01};
        total++;
        if (got.size() != 2 || got[got.size()-1] !== exp_w) begin
            bad++; $display("FAIL jump_second: count=%0d last=%h required 2/%h",
                            got.size(), (got.size() > 0) ? got[got.size()-1] : word_t'(0), exp_w);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] hi, lo;
        auto_ack = 1'b0; wr_ack = 1'b0; got.delete();
        start_dl();
        for (int i = 0; i < 12; i++) put_byte(25'(i), 8'h10 + 8'(i));
        @(negedge clk_sys); dl_wr = 1'b0;
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: overflow=%b required 1", overflow); end
        end_dl();
        repeat (4) @(negedge clk_sys);
        total++;
        if (rom_loaded !== 1'b0) begin bad++; $display("FAIL ovf_loaded_pending: rom_loaded=%b required 0", rom_loaded); end
        auto_ack = 1'b1;
        wait_loaded("ovf_loaded");
        total++;
        if (got.size() != 4) begin bad++; $display("FAIL ovf_count: words=%0d required 4", got.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                hi = 8'h10 + 8'(2 * i);
                lo = 8'h11 + 8'(2 * i);
                exp_w = '{a: 24'(i), d: {hi, lo}, be: 2'b11};
                total++;
                if (got[i] !== exp_w) begin bad++; $display("FAIL ovf_word%0d: got %h required %h", i, got[i], exp_w); end
            end
        end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: overflow=%b required 1", overflow); end
        auto_ack = 1'b0; wr_ack = 1'b0;
        @(negedge clk_sys); dl_active = 1'b1;
        @(negedge clk_sys);
        total++;
        if (overflow !== 1'b0 || rom_loaded !== 1'b0) begin
            bad++; $display("FAIL ovf_restart_clear: overflow=%b rom_loaded=%b required 0/0", overflow, rom_loaded);
        end
    endtask

    task automatic test_async_reset;
        got.delete();
        put_byte(25'd0, 8'h01);
        put_byte(25'd1, 8'h02);
        put_byte(25'd2, 8'h03);
        @(negedge clk_sys); dl_wr = 1'b0;
        total++;
        if (wr_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req: wr_req=%b required 1", wr_req); end
        #2 reset_n = 1'b0; dl_active = 1'b0;
        #1;
        total++;
        if ({wr_req, wr_be, rom_loaded, overflow} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            bad++; $display("FAIL rst_async: req=%b be=%b loaded=%b ovf=%b addr=%h data=%h required all 0",
                            wr_req, wr_be, rom_loaded, overflow, wr_addr, wr_data);
        end
        @(negedge clk_sys);
        @(negedge clk_sys); reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        total++;
        if (wr_req !== 1'b0) begin bad++; $display("FAIL rst_no_stale: wr_req=%b required 0", wr_req); end
        start_dl();
        put_byte(25'd0, 8'h44);
        put_byte(25'd1, 8'h55);
        @(negedge clk_sys); dl_wr = 1'b0;
        end_dl();
        auto_ack = 1'b1;
        wait_loaded("rst_loaded");
        exp_w = '{a: 24'd0, d: 16'h4455, be: 2'b11};
        total++;
        if (got.size() != 1 || got[0] !== exp_w) begin
            bad++; $display("FAIL rst_clean_dl: count=%0d first=%h required 1/%h",
                            got.size(), (got.size() > 0) ? got[0] : word_t'(0), exp_w);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] hi, lo;
        auto_ack = 1'b0; wr_ack = 1'b0; got.delete();
        start_dl();
        for (int i = 0; i < 9; i++) put_byte(25'(i), 8'h80 + 8'(i));
        put_byte(25'd9, 8'h89);
        wr_ack = 1'b1;
        @(negedge clk_sys); dl_wr = 1'b0; wr_ack = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_no_ovf: overflow=%b required 0", overflow); end
        for (int k = 1; k <= 4; k++) begin
            hi = 8'h80 + 8'(2 * k);
            lo = 8'h81 + 8'(2 * k);
            exp_w = '{a: 24'(k), d: {hi, lo}, be: 2'b11};
            head = word_t'({wr_addr, wr_data, wr_be});
            total++;
            if (wr_req !== 1'b1 || head !== exp_w) begin
                bad++; $display("FAIL b2b_word%0d: req=%b head=%h required 1/%h", k, wr_req, head, exp_w);
            end
            wr_ack = 1'b1;
            @(negedge clk_sys);
        end
        wr_ack = 1'b0;
        total++;
        if (wr_req !== 1'b0) begin bad++; $display("FAIL b2b_drained: wr_req=%b required 0", wr_req); end
        end_dl();
        wait_loaded("b2b_loaded");
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf_end: overflow=%b required 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_odd_length();
        test_addr_jump();
        test_overflow();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
